// File: rtl/nand_mux_tree_pipe.sv
// nand_mux_tree_pipe: pipelined N-input, WIDTH-bit multiplexer built from
// registered radix-4 levels with valid/ready flow control on both sides.
//
// Ports:
//   clk, reset_n           - clock (rising edge), async active-low reset
//   in_valid/in_ready      - input handshake (in_ready is combinational from out_ready)
//   in_sel  [SEL_W]        - channel index to forward
//   in_data [N*WIDTH]      - channel k at bits [k*WIDTH +: WIDTH]
//   out_valid/out_ready    - output handshake
//   out_data [WIDTH]       - selected channel data
//   out_sel  [SEL_W]       - in_sel carried with the result
//   out_err                - out-of-range select flag
//   out_count [16]         - completed output transfers (wraps)
//
// Optional feature macro: NAND_MUX_SEL_CHECK_EN enables the out-of-range
// select check driving out_err; otherwise out_err is constant 0.
module nand_mux_tree_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 16,
    localparam int unsigned SEL_W  = (N <= 2) ? 1 : $clog2(N),
    localparam int unsigned STAGES = (SEL_W + 1) / 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_sel,
    output logic                 out_err,
    output logic [15:0]          out_count
);

    localparam int unsigned NP    = 4 ** STAGES;
    localparam int unsigned CNT_W = 16;

    // Inputs padded to a full radix-4 tree; absent channels read as 0.
    logic [NP*WIDTH-1:0] w_in_pad;
    logic                w_in_err;

    assign w_in_pad = (NP*WIDTH)'(in_data);

`ifdef NAND_MUX_SEL_CHECK_EN
    // Out-of-range selects already land on zero padding; only the flag is needed.
    assign w_in_err = ({1'b0, in_sel} >= (SEL_W+1)'(N));
`else
    assign w_in_err = 1'b0;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned OUT_CNT = 4 ** (STAGES - 1 - k);

        logic [4*OUT_CNT*WIDTH-1:0] w_src;
        logic [SEL_W-1:0]           w_src_sel;
        logic                       w_src_valid;
        logic                       w_src_err;
        logic [1:0]                 w_idx;
        logic [OUT_CNT*WIDTH-1:0]   w_red;
        logic                       w_ready;

        logic                       r_valid;
        logic                       r_err;
        logic [SEL_W-1:0]           r_sel;
        logic [OUT_CNT*WIDTH-1:0]   r_data;

        // Upstream source: primary inputs or the previous level's register.
        if (k == 0) begin : g_first
            assign w_src       = w_in_pad;
            assign w_src_sel   = in_sel;
            assign w_src_valid = in_valid;
            assign w_src_err   = w_in_err;
        end else begin : g_next
            assign w_src       = g_stage[k-1].r_data;
            assign w_src_sel   = g_stage[k-1].r_sel;
            assign w_src_valid = g_stage[k-1].r_valid;
            assign w_src_err   = g_stage[k-1].r_err;
        end

        // Ready ripples back from the output; an empty stage is always ready.
        if (k == STAGES - 1) begin : g_last
            assign w_ready = ~r_valid | out_ready;
        end else begin : g_mid
            assign w_ready = ~r_valid | g_stage[k+1].w_ready;
        end

        // Select bits [2k+1:2k]; missing upper bit reads 0 (radix-2 last level).
        assign w_idx = 2'(w_src_sel >> (2 * k));

        // Radix-4 reduction of each group of four.
        always_comb begin
            w_red = '0;
            for (int g = 0; g < int'(OUT_CNT); g++) begin
                case (w_idx)
                    2'd0:    w_red[g*WIDTH +: WIDTH] = w_src[(4*g+0)*WIDTH +: WIDTH];
                    2'd1:    w_red[g*WIDTH +: WIDTH] = w_src[(4*g+1)*WIDTH +: WIDTH];
                    2'd2:    w_red[g*WIDTH +: WIDTH] = w_src[(4*g+2)*WIDTH +: WIDTH];
                    default: w_red[g*WIDTH +: WIDTH] = w_src[(4*g+3)*WIDTH +: WIDTH];
                endcase
            end
        end

        // Stage register: holds everything while stalled, payload loads only with data.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_valid <= 1'b0;
                r_err   <= 1'b0;
                r_sel   <= '0;
                r_data  <= '0;
            end else if (w_ready) begin
                r_valid <= w_src_valid;
                if (w_src_valid) begin
                    r_err  <= w_src_err;
                    r_sel  <= w_src_sel;
                    r_data <= w_red;
                end
            end
        end
    end

    assign in_ready  = g_stage[0].w_ready;
    assign out_valid = g_stage[STAGES-1].r_valid;
    assign out_data  = g_stage[STAGES-1].r_data;
    assign out_sel   = g_stage[STAGES-1].r_sel;
    assign out_err   = g_stage[STAGES-1].r_err;

    // Completed output transfer counter, wraps naturally.
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (out_valid && out_ready) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign out_count = r_count;

endmodule

// File: tb/tb_nand_mux_tree_pipe.sv
// Self-checking bench for nand_mux_tree_pipe: table-driven sweep, hand-written
// flow-control/reset sequences, randomized traffic against a queue model, and
// counter wrap. A second instance with N=12 covers out-of-range selects.
module tb_nand_mux_tree_pipe;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned N      = 16;
    localparam int unsigned SEL_W  = 4;
    localparam int unsigned STAGES = 2;
    localparam int unsigned NB     = 12;

`ifdef NAND_MUX_SEL_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [SEL_W-1:0]     in_sel;
    logic [N*WIDTH-1:0]   in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SEL_W-1:0]     out_sel;
    logic                 out_err;
    logic [15:0]          out_count;

    logic                 b_in_valid;
    logic                 b_in_ready;
    logic [SEL_W-1:0]     b_in_sel;
    logic [NB*WIDTH-1:0]  b_in_data;
    logic                 b_out_valid;
    logic                 b_out_ready;
    logic [WIDTH-1:0]     b_out_data;
    logic [SEL_W-1:0]     b_out_sel;
    logic                 b_out_err;
    logic [15:0]          b_out_count;

    always #5 clk = ~clk;

    nand_mux_tree_pipe #(.WIDTH(WIDTH), .N(N)) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_err   (out_err),
        .out_count (out_count)
    );

    nand_mux_tree_pipe #(.WIDTH(WIDTH), .N(NB)) u_dut_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_sel    (b_in_sel),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .out_sel   (b_out_sel),
        .out_err   (b_out_err),
        .out_count (b_out_count)
    );

    typedef struct {
        logic [SEL_W-1:0] sel;
        logic [WIDTH-1:0] exp;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] sel;
    } item_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t  sweep [16];
    item_t q [$];
    item_t it;
    int    mcount;
    int    nxfer;
    bit    seen_ffff;

    initial begin
        reset_n     = 1'b0;
        in_valid    = 1'b0;
        in_sel      = '0;
        in_data     = '0;
        out_ready   = 1'b1;
        b_in_valid  = 1'b0;
        b_in_sel    = '0;
        b_in_data   = '0;
        b_out_ready = 1'b1;
        for (int k = 0; k < int'(N); k++)  in_data[k*8 +: 8]   = 8'(8'h10 + k);
        for (int k = 0; k < int'(NB); k++) b_in_data[k*8 +: 8] = 8'(8'h40 + k);
        for (int i = 0; i < 16; i++) begin
            sweep[i].sel = 4'(i);
            sweep[i].exp = 8'(8'h10 + i);
        end

        // Reset state
        #1;
        check("rst_in_ready",  32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data), 32'd0);
        check("rst_out_sel",   32'(out_sel), 32'd0);
        check("rst_out_err",   32'(out_err), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;

        // Sweep 0..15 at full rate, latency 2
        out_ready = 1'b1;
        for (int c = 0; c < 18; c++) begin
            in_valid = (c < 16);
            in_sel   = (c < 16) ? sweep[c].sel : 4'd0;
            tick();
            if (c >= 1 && c <= 16) begin
                check("sweep_valid", 32'(out_valid), 32'd1);
                check("sweep_data",  32'(out_data), 32'(sweep[c-1].exp));
                check("sweep_sel",   32'(out_sel), 32'(sweep[c-1].sel));
                check("sweep_err",   32'(out_err), 32'd0);
            end else begin
                check("sweep_idle", 32'(out_valid), 32'd0);
            end
        end
        check("sweep_count", 32'(out_count), 32'd16);

        // Backpressure: two accepted, third blocked, head held
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 4'd3;
        #1 check("bp_ready0", 32'(in_ready), 32'd1);
        tick();
        in_sel = 4'd7;
        #1 check("bp_ready1", 32'(in_ready), 32'd1);
        tick();
        in_sel = 4'd12;
        #1 check("bp_ready_low", 32'(in_ready), 32'd0);
        check("bp_head_valid", 32'(out_valid), 32'd1);
        check("bp_head_data", 32'(out_data), 32'h13);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_data",  32'(out_data), 32'h13);
            check("bp_hold_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1 check("bp_ready_back", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_out1", 32'(out_data), 32'h17);
        tick();
        check("bp_out2_valid", 32'(out_valid), 32'd1);
        check("bp_out2", 32'(out_data), 32'h1C);
        tick();
        check("bp_drained", 32'(out_valid), 32'd0);
        check("bp_count", 32'(out_count), 32'd19);

        // Bubble collapse
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 4'd1;
        tick();
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1;
        in_sel   = 4'd2;
        #1 check("bub_ready_in", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        #1 check("bub_full", 32'(in_ready), 32'd0);
        check("bub_head", 32'(out_data), 32'h11);
        out_ready = 1'b1;
        tick();
        check("bub_second", 32'(out_data), 32'h12);
        tick();
        check("bub_empty", 32'(out_valid), 32'd0);
        check("bub_count", 32'(out_count), 32'd21);

        // Out-of-range select on N=12 instance
        b_in_valid = 1'b1;
        b_in_sel   = 4'd13;
        tick();
        b_in_sel = 4'd11;
        tick();
        b_in_valid = 1'b0;
        check("oor_valid", 32'(b_out_valid), 32'd1);
        check("oor_data",  32'(b_out_data), 32'd0);
        check("oor_err",   32'(b_out_err), 32'(EXP_ERR));
        check("oor_sel",   32'(b_out_sel), 32'd13);
        tick();
        check("inr_data", 32'(b_out_data), 32'h4B);
        check("inr_err",  32'(b_out_err), 32'd0);
        check("inr_sel",  32'(b_out_sel), 32'd11);
        tick();
        check("oor_count", 32'(b_out_count), 32'd2);

        // Reset mid-stream with two elements stalled in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 4'd5;
        tick();
        in_sel = 4'd6;
        tick();
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_count", 32'(out_count), 32'd0);
        check("mrst_ready", 32'(in_ready), 32'd1);
        check("mrst_data",  32'(out_data), 32'd0);
        check("mrst_b_count", 32'(b_out_count), 32'd0);
        tick();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mrst_no_stale", 32'(out_valid), 32'd0);
        end

        // Randomized traffic against an in-order queue model
        mcount = 0;
        q.delete();
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_sel    = 4'($urandom_range(0, 15));
            for (int k = 0; k < 4; k++) in_data[k*32 +: 32] = $urandom();
            #1;
            // Any empty slot anywhere lets the pipe accept.
            check("rnd_in_ready", 32'(in_ready), 32'(out_ready || (q.size() < int'(STAGES))));
            if (out_valid) check("rnd_occupied", 32'(q.size() != 0), 32'd1);
            if (out_valid && out_ready && q.size() != 0) begin
                it = q.pop_front();
                check("rnd_data", 32'(out_data), 32'(it.data));
                check("rnd_sel",  32'(out_sel), 32'(it.sel));
                mcount++;
            end
            if (in_valid && in_ready) begin
                it.sel  = in_sel;
                it.data = in_data[int'(in_sel)*8 +: 8];
                q.push_back(it);
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (out_valid && q.size() != 0) begin
                it = q.pop_front();
                check("drain_data", 32'(out_data), 32'(it.data));
                mcount++;
            end
            tick();
        end
        check("rnd_q_empty", 32'(q.size()), 32'd0);
        check("rnd_count", 32'(out_count), 32'(16'(mcount)));

        // Counter wrap over 65536 output transfers
        reset_n = 1'b0;
        tick();
        reset_n   = 1'b1;
        in_valid  = 1'b1;
        in_sel    = 4'd0;
        out_ready = 1'b1;
        nxfer     = 0;
        seen_ffff = 1'b0;
        for (int c = 0; c < 66000 && nxfer < 65536; c++) begin
            if (out_valid) nxfer++;
            tick();
            if (nxfer == 65535 && !seen_ffff) begin
                seen_ffff = 1'b1;
                check("wrap_ffff", 32'(out_count), 32'hFFFF);
            end
        end
        in_valid = 1'b0;
        check("wrap_reached", 32'(nxfer), 32'd65536);
        check("wrap_zero", 32'(out_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nand_mux_tree_pipe.md
# nand_mux_tree_pipe

Parametrised, pipelined N-input, WIDTH-bit multiplexer built as a tree of registered radix-4 levels, with valid/ready flow control on both sides. It is the next-generation successor to the team's fixed 4:1 single-bit gate-level mux. It is used wherever a wide operand or result bus must be steered from many sources at full clock rate, for example in register-file read ports and bypass networks.

## Interface
- `WIDTH`, 8: data bits per input channel (>=1).
- `N`, 16: number of input channels (2..64).
- `SEL_W`, derived localparam = max(1, clog2(N)): select width.
- `STAGES`, derived localparam = ceil(log4(N)): number of registered tree levels.
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: an input transfer is offered.
- `in_ready` output 1: the pipe can accept a transfer this cycle.
- `in_sel` input SEL_W: channel index to forward.
- `in_data` input N*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
- `out_valid` output 1: result is valid.
- `out_ready` input 1: downstream accepts the result.
- `out_data` output WIDTH: the selected channel's data.
- `out_sel` output SEL_W: `in_sel` carried with the result.
- `out_err` output 1: out-of-range select flag (see Configuration).
- `out_count` output 16: number of completed output transfers.

## Operation
- Transfers:
  - An input transfer occurs on a rising edge with `in_valid & in_ready`.
  - An output transfer occurs on a rising edge with `out_valid & out_ready`.
- Tree structure:
  - Level j (0-based, from the inputs) reduces groups of 4 using select bits [2j+1:2j].
  - The last level may be radix-2 when SEL_W is odd.
  - Missing group members (N not a power of 4) read as 0.
- Stage registers:
  - Each level has its own register holding the partial data, the full `sel`, a `valid` bit and an `err` bit.
  - `sel` and `err` travel with the data through every stage.
- Flow control:
  - Per stage: `ready_k = ~valid_k | ready_(k+1)`. The ready into the last stage is `out_ready`.
  - `in_ready = ready_0`. It is combinational from `out_ready`.
  - A stalled stage holds all of its fields unchanged.
  - Bubbles collapse: an empty stage accepts new data even while downstream is stalled.
- Throughput: one transfer per cycle when `out_ready` is held high.
- `out_data`, `out_sel`, `out_err` and `out_valid` come directly from the last stage's registers.
- `out_count`:
  - Increments by 1 on each output transfer.
  - Wraps 0xFFFF -> 0x0000.
  - Is never decremented.

## Timing
- Latency from input transfer to `out_valid` is STAGES cycles (N=4: 1, N=16: 2, N=64: 3) when not stalled.
- Reset (`reset_n` low, asynchronous, at any time including mid-stream):
  - All stage valid bits clear, so `out_valid` = 0.
  - `out_data` = 0, `out_sel` = 0, `out_err` = 0, `out_count` = 0.
  - In-flight data is discarded.
  - `in_ready` = 1 while reset is asserted.
- Release of reset is synchronised by the environment. The first transfer is legal on the first rising edge with `reset_n` high.
- Simultaneous events:
  - When the last stage is full and `out_ready` is 1, a new element enters stage 0 on the same edge as the output transfer, with no bubble.
  - `out_count` increments exactly once per output transfer, independent of input activity.
- `in_sel` and `in_data` are sampled only on an input transfer. They are don't-care otherwise.

## Configuration
- `NAND_MUX_SEL_CHECK_EN` defined:
  - An input transfer with `in_sel >= N` produces `out_data` = 0 and `out_err` = 1 for that element.
  - For any other `in_sel`, `out_err` = 0.
- `NAND_MUX_SEL_CHECK_EN` not defined:
  - The range check logic is absent.
  - `out_err` is tied to 0.
  - An out-of-range `in_sel` still produces `out_data` = 0, because absent tree inputs read as 0.
  - `out_sel` carries the raw value.

## Test plan
- Reset, then sweep: N=16, WIDTH=8, channel k = 0x10+k, `out_ready`=1. Issue `in_sel` 0..15 on consecutive cycles -> `out_data` 0x10..0x1F starting 2 cycles after the first transfer, one per cycle, `out_count`=16 at the end.
- Backpressure: hold `out_ready`=0 while pushing 3 elements (sel 3, 7, 12) -> `in_ready` drops after 2 are accepted, and `out_data`=0x13 is held stable. Raise `out_ready` -> 0x13, 0x17, 0x1C delivered in order with no loss or duplication.
- Bubble collapse: push 1 element, wait 1 cycle, push another with `out_ready`=0 -> both stages fill and `in_ready`=0 afterwards.
- Out-of-range select: N=12, push `in_sel`=13 -> `out_data`=0. `out_err`=1 with `NAND_MUX_SEL_CHECK_EN` defined; `out_err`=0 without it.
- Reset mid-stream: assert `reset_n`=0 with 2 elements in flight -> `out_valid`=0 and `out_count`=0 immediately, without a clock edge. No stale output appears after release.
- Counter wrap: preload via 65536 transfers -> `out_count` returns to 0x0000.
